// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and its environment (sources, CPU core, handler).
interface interrupt_controller_if #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 4
);
    logic [NUM_SRC-1:0] irq_src;
    logic               nmi_src;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               eoi;
    logic               ina;
    logic               nmi;
    logic               irq;
    logic               busy;
    logic [ID_W-1:0]    cause_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;

    // Environment side: drives sources, mask writes, acknowledge and end-of-interrupt.
    modport master (
        output irq_src, nmi_src, mask_we, mask_wdata, eoi, ina,
        input  nmi, irq, busy, cause_id, pending, mask
    );

    // Controller side.
    modport slave (
        input  irq_src, nmi_src, mask_we, mask_wdata, eoi, ina,
        output nmi, irq, busy, cause_id, pending, mask
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises and edge-detects NUM_SRC maskable sources plus
// one NMI, latches them as pending, and presents one request at a time to the core
// with fixed priority (NMI first, then lowest index). An NMI may preempt one
// in-service maskable interrupt; the interrupted cause is restored on its eoi.
module interrupt_controller #(
    parameter int unsigned        NUM_SRC  = 8,
    parameter int unsigned        ID_W     = 4,
    parameter logic [NUM_SRC-1:0] MASK_RST = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    interrupt_controller_if.slave bus
);

    localparam logic [ID_W-1:0] NMI_ID = ID_W'(NUM_SRC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IRQ_REQ = 3'd1,
        NMI_REQ = 3'd2,
        IRQ_SVC = 3'd3,
        NMI_SVC = 3'd4
    } state_t;

    // Input conditioning flops
    logic [NUM_SRC-1:0] irq_sync1;
    logic [NUM_SRC-1:0] irq_sync2;
    logic [NUM_SRC-1:0] irq_prev;
    logic               nmi_sync1;
    logic               nmi_sync2;
    logic               nmi_prev;

    // Architectural state
    state_t             state_q;
    state_t             state_d;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic               nmi_pend_q;
    logic               nmi_pend_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [ID_W-1:0]    cause_q;
    logic [ID_W-1:0]    cause_d;
    logic [ID_W-1:0]    saved_q;
    logic [ID_W-1:0]    saved_d;
    logic               nested_q;
    logic               nested_d;

    // Registered request outputs
    logic               nmi_q;
    logic               irq_q;
    logic               busy_q;

    // Combinational helpers
    logic [NUM_SRC-1:0] irq_edge;
    logic               nmi_edge;
    logic [NUM_SRC-1:0] eligible;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_id;
    logic               irq_ack;
    logic               nmi_ack;
    logic [NUM_SRC-1:0] clr_vec;

    // Two-flop synchronisers followed by a previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync1 <= '0;
            irq_sync2 <= '0;
            irq_prev  <= '0;
            nmi_sync1 <= 1'b0;
            nmi_sync2 <= 1'b0;
            nmi_prev  <= 1'b0;
        end else begin
            irq_sync1 <= bus.irq_src;
            irq_sync2 <= irq_sync1;
            irq_prev  <= irq_sync2;
            nmi_sync1 <= bus.nmi_src;
            nmi_sync2 <= nmi_sync1;
            nmi_prev  <= nmi_sync2;
        end
    end

    assign irq_edge  = irq_sync2 & ~irq_prev;
    assign nmi_edge  = nmi_sync2 & ~nmi_prev;
    assign eligible  = pending_q & mask_q;
    assign sel_valid = |eligible;

    // Fixed-priority pick: lowest-index enabled pending source.
    always_comb begin
        sel_id = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // Request/service sequencing.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        saved_d  = saved_q;
        nested_d = nested_q;
        irq_ack  = 1'b0;
        nmi_ack  = 1'b0;

        case (state_q)
            IDLE: begin
                if (nmi_pend_q) begin
                    state_d = NMI_REQ;
                    cause_d = NMI_ID;
                end else if (sel_valid) begin
                    state_d = IRQ_REQ;
                    cause_d = sel_id;
                end
            end
            IRQ_REQ: begin
                if (bus.ina) begin
                    state_d = IRQ_SVC;
                    irq_ack = 1'b1;
                end else if (nmi_pend_q) begin
                    // Abandon the maskable request; its bit stays pending.
                    state_d = NMI_REQ;
                    cause_d = NMI_ID;
                end
            end
            IRQ_SVC: begin
                if (bus.eoi) begin
                    state_d = IDLE;
                end else if (nmi_pend_q) begin
                    state_d  = NMI_REQ;
                    saved_d  = cause_q;
                    nested_d = 1'b1;
                    cause_d  = NMI_ID;
                end
            end
            NMI_REQ: begin
                if (bus.ina) begin
                    state_d = NMI_SVC;
                    nmi_ack = 1'b1;
                end
            end
            NMI_SVC: begin
                if (bus.eoi) begin
                    if (nested_q) begin
                        state_d  = IRQ_SVC;
                        cause_d  = saved_q;
                        nested_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending clear decode for the acknowledged maskable source.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clr_vec[i] = irq_ack && (cause_q == ID_W'(i));
        end
    end

    // A new edge wins over a same-cycle clear.
    assign pending_d  = (pending_q & ~clr_vec) | irq_edge;
    assign nmi_pend_d = (nmi_pend_q & ~nmi_ack) | nmi_edge;

    // State, pending, mask and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= MASK_RST;
            cause_q    <= '0;
            saved_q    <= '0;
            nested_q   <= 1'b0;
            nmi_q      <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            cause_q    <= cause_d;
            saved_q    <= saved_d;
            nested_q   <= nested_d;
            nmi_q      <= (state_d == NMI_REQ);
            irq_q      <= (state_d == IRQ_REQ);
            busy_q     <= (state_d == IRQ_SVC) || (state_d == NMI_SVC);
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
        end
    end

    assign bus.nmi      = nmi_q;
    assign bus.irq      = irq_q;
    assign bus.busy     = busy_q;
    assign bus.cause_id = cause_q;
    assign bus.pending  = pending_q;
    assign bus.mask     = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a context-stack reference model.
module tb_interrupt_controller;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned ID_W    = 4;
    localparam int          NMI_ID  = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   chk_en;

    interrupt_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

    interrupt_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .MASK_RST(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw-sample history, pending set, an outstanding request
    // (0 none, 1 maskable, 2 nmi) and a stack of in-service causes.
    logic [7:0] s1, s2, s3, m_pend, m_mask, m_edge;
    logic       n1, n2, n3, m_npend, m_nedge;
    int         m_req;
    int         m_req_id;
    int         m_stack[$];
    int         m_top;

    function automatic int lowest(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 = '0; s2 = '0; s3 = '0; n1 = 0; n2 = 0; n3 = 0;
            m_pend = '0; m_npend = 0; m_mask = 8'hFF;
            m_req = 0; m_req_id = 0;
            m_stack.delete();
        end else begin
            // A rise sampled two edges ago that was low three edges ago becomes pending now.
            m_edge  = s2 & ~s3;
            m_nedge = n2 & ~n3;
            s3 = s2; s2 = s1; s1 = bus.irq_src;
            n3 = n2; n2 = n1; n1 = bus.nmi_src;
            if (m_req == 1) begin
                if (bus.ina) begin
                    m_stack.push_back(m_req_id);
                    m_pend[m_req_id] = 1'b0;
                    m_req = 0;
                end else if (m_npend) begin
                    m_req = 2; m_req_id = NMI_ID;
                end
            end else if (m_req == 2) begin
                if (bus.ina) begin
                    m_stack.push_back(NMI_ID);
                    m_npend = 1'b0;
                    m_req = 0;
                end
            end else if (m_stack.size() > 0) begin
                m_top = m_stack[$];
                if (bus.eoi) void'(m_stack.pop_back());
                else if (m_top != NMI_ID && m_npend) begin
                    m_req = 2; m_req_id = NMI_ID;
                end
            end else begin
                if (m_npend) begin
                    m_req = 2; m_req_id = NMI_ID;
                end else if ((m_pend & m_mask) != 0) begin
                    m_req = 1; m_req_id = lowest(m_pend & m_mask);
                end
            end
            m_pend  = m_pend | m_edge;
            m_npend = m_npend | m_nedge;
            if (bus.mask_we) m_mask = bus.mask_wdata;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("irq", bus.irq, m_req == 1);
            check("nmi", bus.nmi, m_req == 2);
            check("busy", bus.busy, (m_req == 0) && (m_stack.size() != 0));
            check("pending", bus.pending, m_pend);
            check("mask", bus.mask, m_mask);
            if (m_req != 0) check("cause_req", bus.cause_id, m_req_id);
            else if (m_stack.size() != 0) check("cause_svc", bus.cause_id, m_stack[$]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ina();
        bus.ina = 1'b1; cyc(1); bus.ina = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; chk_en = 0;
        rst_n = 1'b0;
        bus.irq_src = '0; bus.nmi_src = 0; bus.mask_we = 0; bus.mask_wdata = '0;
        bus.eoi = 0; bus.ina = 0;
        cyc(2);
        check("rst irq", bus.irq, 0);
        check("rst nmi", bus.nmi, 0);
        check("rst busy", bus.busy, 0);
        check("rst cause", bus.cause_id, 0);
        check("rst pending", bus.pending, 0);
        check("rst mask", bus.mask, 8'hFF);
        rst_n = 1'b1;
        chk_en = 1;
        cyc(2);

        // Latency: request appears on the 4th edge after the rise
        bus.irq_src[3] = 1'b1;
        cyc(3);
        check("lat irq early", bus.irq, 0);
        cyc(1);
        check("lat irq", bus.irq, 1);
        check("lat cause", bus.cause_id, 3);
        pulse_ina();
        check("lat ack irq", bus.irq, 0);
        check("lat ack busy", bus.busy, 1);
        check("lat ack pend3", bus.pending[3], 0);
        bus.irq_src = '0;
        pulse_eoi();
        check("lat eoi busy", bus.busy, 0);
        cyc(4);

        // Priority: 2 before 5, one idle cycle between
        bus.irq_src = 8'h24;
        cyc(4);
        check("pri irq", bus.irq, 1);
        check("pri cause2", bus.cause_id, 2);
        pulse_ina();
        check("pri pend", bus.pending, 8'h20);
        pulse_eoi();
        check("pri idle irq", bus.irq, 0);
        check("pri idle busy", bus.busy, 0);
        cyc(1);
        check("pri irq5", bus.irq, 1);
        check("pri cause5", bus.cause_id, 5);
        pulse_ina(); pulse_eoi();
        bus.irq_src = '0;
        cyc(4);

        // Masking
        bus.mask_we = 1; bus.mask_wdata = 8'hFE; cyc(1); bus.mask_we = 0;
        check("msk fe", bus.mask, 8'hFE);
        bus.irq_src = 8'h01;
        cyc(5);
        check("msk pend0", bus.pending, 8'h01);
        check("msk irq0", bus.irq, 0);
        bus.mask_we = 1; bus.mask_wdata = 8'hFF; cyc(1); bus.mask_we = 0;
        check("msk ff irq", bus.irq, 0);
        cyc(1);
        check("msk unmask irq", bus.irq, 1);
        check("msk unmask cause", bus.cause_id, 0);
        pulse_ina(); pulse_eoi();
        bus.irq_src = '0;
        cyc(4);

        // NMI preempts a pending maskable request
        bus.irq_src = 8'h10;
        cyc(4);
        check("pre irq", bus.irq, 1);
        check("pre cause4", bus.cause_id, 4);
        bus.nmi_src = 1;
        cyc(3);
        check("pre still irq", bus.irq, 1);
        cyc(1);
        check("pre nmi", bus.nmi, 1);
        check("pre irq drop", bus.irq, 0);
        check("pre cause8", bus.cause_id, 8);
        pulse_ina();
        check("pre busy", bus.busy, 1);
        pulse_eoi();
        check("pre idle", bus.busy, 0);
        cyc(1);
        check("pre rereq", bus.irq, 1);
        check("pre rereq cause", bus.cause_id, 4);
        pulse_ina(); pulse_eoi();
        bus.irq_src = '0; bus.nmi_src = 0;
        cyc(4);

        // Nesting: NMI during maskable service, cause restored afterwards
        bus.irq_src = 8'h02;
        cyc(4);
        pulse_ina();
        check("nest svc cause", bus.cause_id, 1);
        bus.nmi_src = 1;
        cyc(4);
        check("nest nmi", bus.nmi, 1);
        check("nest busy drop", bus.busy, 0);
        check("nest cause8", bus.cause_id, 8);
        pulse_ina();
        check("nest nmi svc", bus.busy, 1);
        pulse_eoi();
        check("nest restore busy", bus.busy, 1);
        check("nest restore cause", bus.cause_id, 1);
        pulse_eoi();
        check("nest idle", bus.busy, 0);
        bus.irq_src = '0; bus.nmi_src = 0;
        cyc(4);

        // Asynchronous reset during service
        bus.irq_src = 8'h01;
        cyc(4);
        pulse_ina();
        bus.irq_src = 8'h31;
        cyc(3);
        check("ar busy", bus.busy, 1);
        check("ar pend", bus.pending, 8'h30);
        #2 rst_n = 1'b0;
        #1;
        check("ar irq", bus.irq, 0);
        check("ar nmi", bus.nmi, 0);
        check("ar busy0", bus.busy, 0);
        check("ar cause", bus.cause_id, 0);
        check("ar pend0", bus.pending, 0);
        check("ar mask", bus.mask, 8'hFF);
        bus.irq_src = '0; bus.nmi_src = 0;
        cyc(1);
        rst_n = 1'b1;
        bus.eoi = 1; bus.ina = 1; cyc(1); bus.eoi = 0; bus.ina = 0;
        cyc(2);
        check("ar post busy", bus.busy, 0);
        check("ar post irq", bus.irq, 0);
        check("ar post pend", bus.pending, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                int b;
                b = int'($urandom_range(7));
                bus.irq_src[b] = ~bus.irq_src[b];
            end
            if ($urandom_range(39) == 0) bus.nmi_src = ~bus.nmi_src;
            bus.ina = ($urandom_range(2) == 0);
            bus.eoi = ($urandom_range(3) == 0);
            bus.mask_we = ($urandom_range(19) == 0);
            bus.mask_wdata = 8'($urandom());
        end
        @(negedge clk);
        bus.ina = 0; bus.eoi = 0; bus.mask_we = 0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
